awb_gamma_lut: RTL and testbench

- Per-channel gamma/tone-curve stage directly downstream of the white-balance stage; consumes its vs/hs/de/rgb/data_choice outputs.
- Each colour component indexes a 256-entry, 8-bit LUT. There is one LUT per channel.
- Each LUT is double-buffered. The host writes the shadow bank, then commits. Banks swap only at a frame boundary (vs falling edge), so no frame is ever mapped with a half-written table.

---
 rtl/awb_gamma_lut.sv | 178 +++++++++++++++++
 tb/tb_awb_gamma_lut.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/awb_gamma_lut.sv
// Per-channel gamma LUT stage with double-buffered tables that swap on the vs falling edge.
// Optional AWB_GAMMA_BYPASS_EN adds I_bypass, sampled per frame, forcing identity output.
module awb_gamma_lut #(
  parameter int DW            = 8,
  parameter bit INIT_IDENTITY = 1'b1
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_vs,
  input  logic            I_hs,
  input  logic            I_de,
  input  logic [3*DW-1:0] I_rgb,
  input  logic            I_data_choice,
  input  logic            I_lut_wr_en,
  input  logic [1:0]      I_lut_wr_sel,
  input  logic [DW-1:0]   I_lut_wr_addr,
  input  logic [DW-1:0]   I_lut_wr_data,
  input  logic            I_lut_commit,
`ifdef AWB_GAMMA_BYPASS_EN
  input  logic            I_bypass,
`endif
  output logic            O_lut_pending,
  output logic            O_lut_wr_err,
  output logic            O_vs,
  output logic            O_hs,
  output logic            O_de,
  output logic [3*DW-1:0] O_rgb,
  output logic            O_data_choice
);

  // state    | meaning
  // ST_ID       | identity mapping, nothing pending
  // ST_ID_PEND  | identity mapping, swap requested
  // ST_RUN      | LUT active
  // ST_RUN_PEND | LUT active, swap requested
  typedef enum logic [1:0] {ST_ID, ST_ID_PEND, ST_RUN, ST_RUN_PEND} state_t;
  localparam state_t RST_STATE = INIT_IDENTITY ? ST_ID : ST_RUN;

  state_t state_q, state_d;
  logic   act_q, act_d;
  logic   vs_dly_q, vs_dly_d;
  logic   err_q, err_d;
  logic   bypass_q;
  logic   pending, vs_neg, wr_ok, cm_ok, id_mode;

  assign pending = (state_q == ST_ID_PEND) || (state_q == ST_RUN_PEND);
  assign vs_neg  = vs_dly_q & ~I_vs;
  assign wr_ok   = I_lut_wr_en & ~pending;
  assign cm_ok   = I_lut_commit & ~pending;
  assign id_mode = (state_q == ST_ID) || (state_q == ST_ID_PEND) || bypass_q;

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    vs_dly_d = I_vs;
    err_d    = pending & (I_lut_wr_en | I_lut_commit);
    case (state_q)
      ST_ID:       if (cm_ok) state_d = ST_ID_PEND;
      ST_ID_PEND:  if (vs_neg) begin
                     state_d = ST_RUN;
                     act_d   = ~act_q;
                   end
      ST_RUN:      if (cm_ok) state_d = ST_RUN_PEND;
      ST_RUN_PEND: if (vs_neg) begin
                     state_d = ST_RUN;
                     act_d   = ~act_q;
                   end
      default:     state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= RST_STATE;
      act_q    <= 1'b0;
      vs_dly_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      vs_dly_q <= vs_dly_d;
      err_q    <= err_d;
    end
  end

`ifdef AWB_GAMMA_BYPASS_EN
  logic bypass_d;
  always_comb begin
    bypass_d = bypass_q;
    if (vs_neg) bypass_d = I_bypass;
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) bypass_q <= 1'b0;
    else          bypass_q <= bypass_d;
  end
`else
  assign bypass_q = 1'b0;
`endif

  // Two banks per channel: act selects the read bank, writes always land in the other one.
  logic [3*DW-1:0] ram_rd;
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [DW-1:0] bank0 [2**DW];
    logic [DW-1:0] bank1 [2**DW];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_addr;
    logic          we;

    assign we      = wr_ok & ((I_lut_wr_sel == 2'(c)) | (I_lut_wr_sel == 2'd3));
    assign rd_addr = I_rgb[(2-c)*DW +: DW];

    always_ff @(posedge I_clk) begin
      if (we && act_q)  bank0[I_lut_wr_addr] <= I_lut_wr_data;
      if (we && !act_q) bank1[I_lut_wr_addr] <= I_lut_wr_data;
      rd_data_q <= act_q ? bank1[rd_addr] : bank0[rd_addr];
    end

    assign ram_rd[(2-c)*DW +: DW] = rd_data_q;
  end

  logic            s1_vs_q, s1_hs_q, s1_de_q, s1_dc_q, s1_id_q;
  logic            s1_vs_d, s1_hs_d, s1_de_d, s1_dc_d, s1_id_d;
  logic [3*DW-1:0] s1_raw_q, s1_raw_d;
  logic            out_vs_q, out_hs_q, out_de_q, out_dc_q;
  logic            out_vs_d, out_hs_d, out_de_d, out_dc_d;
  logic [3*DW-1:0] out_rgb_q, out_rgb_d;

  always_comb begin
    s1_vs_d   = I_vs;
    s1_hs_d   = I_hs;
    s1_de_d   = I_de;
    s1_dc_d   = I_data_choice;
    s1_id_d   = id_mode;
    s1_raw_d  = I_rgb;
    out_vs_d  = s1_vs_q;
    out_hs_d  = s1_hs_q;
    out_de_d  = s1_de_q;
    out_dc_d  = s1_dc_q;
    out_rgb_d = s1_id_q ? s1_raw_q : ram_rd;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_vs_q   <= 1'b0;
      s1_hs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_dc_q   <= 1'b0;
      s1_id_q   <= 1'b0;
      s1_raw_q  <= '0;
      out_vs_q  <= 1'b0;
      out_hs_q  <= 1'b0;
      out_de_q  <= 1'b0;
      out_dc_q  <= 1'b0;
      out_rgb_q <= '0;
    end else begin
      s1_vs_q   <= s1_vs_d;
      s1_hs_q   <= s1_hs_d;
      s1_de_q   <= s1_de_d;
      s1_dc_q   <= s1_dc_d;
      s1_id_q   <= s1_id_d;
      s1_raw_q  <= s1_raw_d;
      out_vs_q  <= out_vs_d;
      out_hs_q  <= out_hs_d;
      out_de_q  <= out_de_d;
      out_dc_q  <= out_dc_d;
      out_rgb_q <= out_rgb_d;
    end
  end

  assign O_lut_pending = pending;
  assign O_lut_wr_err  = err_q;
  assign O_vs          = out_vs_q;
  assign O_hs          = out_hs_q;
  assign O_de          = out_de_q;
  assign O_data_choice = out_dc_q;
  assign O_rgb         = out_rgb_q;

endmodule

// File: tb/tb_awb_gamma_lut.sv
// Scoreboard bench for awb_gamma_lut: random pixels checked against a bank-level table model.
module tb_awb_gamma_lut;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 0, hs = 0, de = 0, dc = 0;
  logic [23:0] rgb = '0;
  logic        wr_en = 0, commit = 0;
  logic [1:0]  wr_sel = '0;
  logic [7:0]  wr_addr = '0, wr_data = '0;
  logic        bypass = 0;
  logic        o_pend, o_err, o_vs, o_hs, o_de, o_dc;
  logic [23:0] o_rgb;

  always #5 clk = ~clk;

  awb_gamma_lut #(.DW(8), .INIT_IDENTITY(1'b1)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_hs(hs), .I_de(de), .I_rgb(rgb),
    .I_data_choice(dc), .I_lut_wr_en(wr_en), .I_lut_wr_sel(wr_sel),
    .I_lut_wr_addr(wr_addr), .I_lut_wr_data(wr_data), .I_lut_commit(commit),
`ifdef AWB_GAMMA_BYPASS_EN
    .I_bypass(bypass),
`endif
    .O_lut_pending(o_pend), .O_lut_wr_err(o_err), .O_vs(o_vs), .O_hs(o_hs),
    .O_de(o_de), .O_rgb(o_rgb), .O_data_choice(o_dc));

  typedef struct packed {logic vs, hs, de, dc; logic [23:0] rgb;} pix_t;
  pix_t       pq[$];
  logic [1:0] cq[$];
  int         n_cmp = 0, n_bad = 0;

  // Reference model: two tables per channel, one active, identity until first swap.
  logic [7:0] tab [3][2][256];
  logic       m_act = 0, m_id = 1, m_pend = 0, m_vsp = 0, m_byp = 0;
  logic       g_fix = 0, g_byp = 0;
  logic [23:0] g_pix = '0, g_exp = '0;

  task automatic model_reset();
    m_act = 0; m_id = 1; m_pend = 0; m_vsp = 0; m_byp = 0;
  endtask

  task automatic cyc(input logic v, input logic w, input logic [1:0] sel,
                     input logic [7:0] a, input logic [7:0] d, input logic cm);
    pix_t       e;
    logic [23:0] p;
    logic       vneg, err;
    @(negedge clk);
    p = g_fix ? g_pix : 24'($urandom);
    e.vs = v; e.hs = 1'($urandom); e.de = 1'($urandom); e.dc = 1'($urandom);
    vs = v; hs = e.hs; de = e.de; dc = e.dc; rgb = p;
    wr_en = w; wr_sel = sel; wr_addr = a; wr_data = d; commit = cm; bypass = g_byp;
    if (m_id || m_byp) e.rgb = p;
    else for (int ch = 0; ch < 3; ch++)
      e.rgb[(2-ch)*8 +: 8] = tab[ch][m_act][p[(2-ch)*8 +: 8]];
    if (g_fix) e.rgb = g_exp;
    pq.push_back(e);
    vneg = m_vsp & ~v;
    err  = m_pend & (w | cm);
    if (!m_pend && w)
      for (int ch = 0; ch < 3; ch++)
        if (sel == 2'd3 || sel == 2'(ch)) tab[ch][!m_act][a] = d;
    if (m_pend && vneg) begin
      m_act = !m_act; m_id = 0; m_pend = 0;
    end else if (!m_pend && cm) m_pend = 1;
    if (vneg) m_byp = g_byp;
    m_vsp = v;
    cq.push_back({m_pend, err});
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) cyc(v, 0, 2'd0, 8'd0, 8'd0, 0);
  endtask

  task automatic vs_pulse();
    idle(3, 1);
  endtask

  task automatic fixed(input logic [23:0] p, input logic [23:0] x, input int n);
    g_fix = 1; g_pix = p; g_exp = x;
    idle(n, 0);
    g_fix = 0;
  endtask

  initial begin
    pix_t       e;
    logic [1:0] c;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (cq.size() > 0) begin
          c = cq.pop_front();
          n_cmp++;
          if ({o_pend, o_err} !== c) begin
            n_bad++;
            $display("FAIL ctl t=%0t pend/err got %b%b exp %b%b", $time, o_pend, o_err, c[1], c[0]);
          end
        end
        if (pq.size() >= 2) begin
          e = pq.pop_front();
          n_cmp++;
          if ({o_vs, o_hs, o_de, o_dc, o_rgb} !== e) begin
            n_bad++;
            $display("FAIL pix t=%0t got vs%b hs%b de%b dc%b rgb=%06h exp vs%b hs%b de%b dc%b rgb=%06h",
                     $time, o_vs, o_hs, o_de, o_dc, o_rgb, e.vs, e.hs, e.de, e.dc, e.rgb);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_vs, o_hs, o_de, o_dc, o_rgb, o_pend, o_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got %h exp 0", {o_vs, o_hs, o_de, o_dc, o_rgb, o_pend, o_err});
    end
    rst_n = 1'b1;

    // identity from reset
    fixed(24'h3C80FF, 24'h3C80FF, 4);
    idle(20, 0);

    // inverse table on all channels, commit, swap at next vs falling edge
    for (int a = 0; a < 256; a++) cyc(0, 1, 2'd3, 8'(a), 8'(255 - a), 0);
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    idle(10, 0);
    vs_pulse();
    idle(1, 0);
    fixed(24'h3C80FF, 24'hC37F00, 4);
    fixed(24'h00FF00, 24'hFF00FF, 2);
    idle(30, 0);

    // random per-channel table into shadow; write+commit in the same cycle
    for (int ch = 0; ch < 3; ch++)
      for (int a = 0; a < 256; a++)
        cyc(0, 1, 2'(ch), 8'(a), 8'($urandom), (ch == 2 && a == 255));
    cyc(0, 1, 2'd3, 8'h3C, 8'h55, 0);
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    idle(5, 0);
    idle(2, 1);
    cyc(1, 0, 2'd0, 8'd0, 8'd0, 0);
    cyc(0, 1, 2'd3, 8'h80, 8'h11, 0);
    idle(30, 0);

    // recommit without rewriting: inverse table returns, dropped 0x3C write left no trace
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    vs_pulse();
    idle(2, 0);
    fixed(24'h3C80FF, 24'hC37F00, 3);

    // commit coinciding with vs falling edge swaps only at the following edge
    vs_pulse();
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    idle(25, 0);
    vs_pulse();
    idle(20, 0);

    // asynchronous reset while a swap is pending mid-frame
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    idle(6, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_vs, o_hs, o_de, o_dc, o_rgb, o_pend, o_err} !== '0) begin
      n_bad++;
      $display("FAIL async_rst got %h exp 0", {o_vs, o_hs, o_de, o_dc, o_rgb, o_pend, o_err});
    end
    pq.delete(); cq.delete();
    vs = 0; wr_en = 0; commit = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fixed(24'h3C80FF, 24'h3C80FF, 3);
    idle(10, 0);
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    vs_pulse();
    idle(2, 0);
    fixed(24'h3C80FF, 24'hC37F00, 3);

`ifdef AWB_GAMMA_BYPASS_EN
    g_byp = 1;
    fixed(24'h3C80FF, 24'hC37F00, 5);
    cyc(0, 0, 2'd0, 8'd0, 8'd0, 1);
    vs_pulse();
    fixed(24'h3C80FF, 24'h3C80FF, 5);
    idle(15, 0);
    g_byp = 0;
    vs_pulse();
    idle(15, 0);
`endif

    idle(4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
